branch_redirect: RTL and testbench

- Resolves branch/jump instructions at execute and drives the redirect inputs of the PC generator: target address `pcBranch` and select `originPc`.
- On a taken branch it raises `originPc`, holds `pcBranch`, then squashes wrong-path instructions for a fixed number of cycles.
- Sits between execute and the PC generator, closing the fetch loop.

---
 rtl/branch_redirect.sv | 150 +++++++++++++++
 tb/tb_branch_redirect.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect.sv
// Branch/jump resolution at execute: evaluates the condition, computes the target,
// and drives the PC generator redirect (pcBranch/originPc) followed by a wrong-path squash.
module branch_redirect #(
  parameter int unsigned PCLEN        = 10,
  parameter int unsigned DATALEN      = 16,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inValid,
  input  logic [2:0]         brType,
  input  logic [PCLEN-1:0]   pcIn,
  input  logic [PCLEN-1:0]   imm,
  input  logic [DATALEN-1:0] rsVal,
  input  logic [DATALEN-1:0] rtVal,
  output logic [PCLEN-1:0]   pcBranch,
  output logic               originPc,
  output logic               flush,
  output logic               busy,
  output logic [15:0]        takenCnt
);

  // Out-of-range squash lengths fall back to a single flush cycle
  localparam int unsigned FLUSH_EFF = ((FLUSH_CYCLES >= 1) && (FLUSH_CYCLES <= 7)) ?
                                      FLUSH_CYCLES : 1;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned TAKEN_W   = 16;

  localparam logic [2:0] BR_BEQ = 3'b001;
  localparam logic [2:0] BR_BNE = 3'b010;
  localparam logic [2:0] BR_BLT = 3'b011;
  localparam logic [2:0] BR_BGE = 3'b100;
  localparam logic [2:0] BR_JAL = 3'b101;
  localparam logic [2:0] BR_JR  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PCLEN-1:0]     pc_branch_q, pc_branch_d;
  logic                 origin_q, origin_d;
  logic                 flush_q, flush_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TAKEN_W-1:0]   taken_cnt_q, taken_cnt_d;

  logic                 taken_c;
  logic [PCLEN-1:0]     rel_tgt_c;
  logic [PCLEN-1:0]     jr_tgt_c;
  logic [PCLEN-1:0]     target_c;

  // Branch condition evaluation
  always_comb begin
    taken_c = 1'b0;
    case (brType)
      BR_BEQ:  taken_c = (rsVal == rtVal);
      BR_BNE:  taken_c = (rsVal != rtVal);
      BR_BLT:  taken_c = ($signed(rsVal) <  $signed(rtVal));
      BR_BGE:  taken_c = ($signed(rsVal) >= $signed(rtVal));
      BR_JAL:  taken_c = 1'b1;
      BR_JR:   taken_c = 1'b1;
      default: taken_c = 1'b0;
    endcase
  end

  // PC-relative target wraps naturally in PCLEN bits; JR target is word aligned
  assign rel_tgt_c = PCLEN'(pcIn + PCLEN'(imm << 2));
  assign jr_tgt_c  = {rsVal[PCLEN-1:2], 2'b00};
  assign target_c  = (brType == BR_JR) ? jr_tgt_c : rel_tgt_c;

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_branch_q <= '0;
      origin_q    <= 1'b0;
      flush_q     <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_branch_q <= pc_branch_d;
      origin_q    <= origin_d;
      flush_q     <= flush_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    pc_branch_d = pc_branch_q;
    origin_d    = 1'b0;
    flush_d     = flush_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    taken_cnt_d = taken_cnt_q;

    case (state_q)
      S_IDLE: begin
        flush_d = 1'b0;
        busy_d  = 1'b0;
        if (inValid && taken_c) begin
          state_d     = S_REDIRECT;
          pc_branch_d = target_c;
          origin_d    = 1'b1;
          flush_d     = 1'b1;
          busy_d      = 1'b1;
          taken_cnt_d = (taken_cnt_q == {TAKEN_W{1'b1}}) ? taken_cnt_q
                                                         : taken_cnt_q + TAKEN_W'(1);
        end
      end
      S_REDIRECT: begin
        state_d = S_FLUSH;
        cnt_d   = CNT_W'(FLUSH_EFF - 1);
        flush_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          flush_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          flush_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        flush_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign pcBranch = pc_branch_q;
  assign originPc = origin_q;
  assign flush    = flush_q;
  assign busy     = busy_q;
  assign takenCnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_redirect.sv
// Bench for branch_redirect: directed vector table, hand-written corner sequences,
// and random traffic checked against a cycle-count reference model.
module tb_branch_redirect;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid;
  logic [2:0]  brType;
  logic [9:0]  pcIn;
  logic [9:0]  imm;
  logic [15:0] rsVal;
  logic [15:0] rtVal;
  logic [9:0]  pcBranch;
  logic        originPc;
  logic        flush;
  logic        busy;
  logic [15:0] takenCnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_pc, m_cnt, m_left;
  bit m_origin, m_flush, m_busy;

  typedef struct {
    logic        v;
    logic [2:0]  br;
    logic [9:0]  pc;
    logic [9:0]  im;
    logic [15:0] rs;
    logic [15:0] rt;
    logic [9:0]  exp_pc;
    logic        exp_origin;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[10];

  branch_redirect #(.PCLEN(10), .DATALEN(16), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .brType(brType), .pcIn(pcIn),
    .imm(imm), .rsVal(rsVal), .rtVal(rtVal), .pcBranch(pcBranch),
    .originPc(originPc), .flush(flush), .busy(busy), .takenCnt(takenCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] b, input logic [15:0] rs, input logic [15:0] rt);
    int a, c;
    a = int'($signed(rs));
    c = int'($signed(rt));
    case (b)
      3'd1: return rs == rt;
      3'd2: return rs != rt;
      3'd3: return a < c;
      3'd4: return a >= c;
      3'd5, 3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int ref_target(input logic [2:0] b, input logic [9:0] p,
                                    input logic [9:0] im, input logic [15:0] rs);
    int t;
    if (b == 3'd6) begin
      t = int'(rs) % 1024;
      return t - (t % 4);
    end
    t = int'(p) + 4 * int'($signed(im));
    return ((t % 1024) + 1024) % 1024;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_cnt = 0; m_left = 0;
    m_origin = 0; m_flush = 0; m_busy = 0;
  endtask

  task automatic model_step(input logic v, input logic [2:0] b, input logic [9:0] p,
                            input logic [9:0] im, input logic [15:0] rs, input logic [15:0] rt);
    if (!m_busy) begin
      if (v && ref_taken(b, rs, rt)) begin
        m_pc = ref_target(b, p, im, rs);
        m_origin = 1; m_flush = 1; m_busy = 1;
        if (m_cnt < 65535) m_cnt++;
        m_left = FC;
      end else begin
        m_origin = 0;
      end
    end else begin
      m_origin = 0;
      if (m_left == 0) begin
        m_flush = 0; m_busy = 0;
      end else begin
        m_left--;
      end
    end
  endtask

  // Present one instruction for one cycle, then compare all outputs to the model
  task automatic cycle(input logic v, input logic [2:0] b, input logic [9:0] p,
                       input logic [9:0] im, input logic [15:0] rs, input logic [15:0] rt);
    inValid = v; brType = b; pcIn = p; imm = im; rsVal = rs; rtVal = rt;
    @(posedge clk);
    model_step(v, b, p, im, rs, rt);
    #1;
    chk("pcBranch", 32'(pcBranch), 32'(m_pc));
    chk("originPc", 32'(originPc), 32'(m_origin));
    chk("flush",    32'(flush),    32'(m_flush));
    chk("busy",     32'(busy),     32'(m_busy));
    chk("takenCnt", 32'(takenCnt), 32'(m_cnt));
  endtask

  task automatic rand_cycle();
    logic [15:0] rs, rt;
    rs = 16'($urandom);
    rt = ($urandom_range(0, 2) == 0) ? rs : 16'($urandom);
    cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 10'($urandom),
          10'($urandom), rs, rt);
  endtask

  // Feed random wrong-path traffic while the model says the block is busy
  task automatic drain();
    for (int k = 0; k < 10 && m_busy; k++) rand_cycle();
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'd1, 10'h010, 10'd3,   16'h0005, 16'h0005, 10'h01C, 1'b1, 16'd1};
    vecs[1] = '{1'b1, 3'd3, 10'h020, 10'd2,   16'hFFFF, 16'h0001, 10'h028, 1'b1, 16'd2};
    vecs[2] = '{1'b1, 3'd4, 10'h040, 10'd1,   16'hFFFF, 16'h0001, 10'h028, 1'b0, 16'd2};
    vecs[3] = '{1'b1, 3'd2, 10'h3FC, 10'd1,   16'h0001, 16'h0002, 10'h000, 1'b1, 16'd3};
    vecs[4] = '{1'b1, 3'd6, 10'h000, 10'd0,   16'h0123, 16'h0000, 10'h120, 1'b1, 16'd4};
    vecs[5] = '{1'b1, 3'd5, 10'h100, 10'h3FE, 16'h0000, 16'h0000, 10'h0F8, 1'b1, 16'd5};
    vecs[6] = '{1'b1, 3'd0, 10'h200, 10'd5,   16'h0007, 16'h0007, 10'h0F8, 1'b0, 16'd5};
    vecs[7] = '{1'b1, 3'd7, 10'h200, 10'd5,   16'h0007, 16'h0007, 10'h0F8, 1'b0, 16'd5};
    vecs[8] = '{1'b1, 3'd1, 10'h200, 10'd5,   16'h0007, 16'h0008, 10'h0F8, 1'b0, 16'd5};
    vecs[9] = '{1'b0, 3'd1, 10'h200, 10'd5,   16'h0007, 16'h0007, 10'h0F8, 1'b0, 16'd5};

    // Reset held with a taken branch at the input
    model_reset();
    rst_n = 1'b0;
    inValid = 1'b1; brType = 3'd1; pcIn = 10'h010; imm = 10'd3; rsVal = 16'd5; rtVal = 16'd5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst pcBranch", 32'(pcBranch), 32'd0);
    chk("rst originPc", 32'(originPc), 32'd0);
    chk("rst flush",    32'(flush),    32'd0);
    chk("rst busy",     32'(busy),     32'd0);
    chk("rst takenCnt", 32'(takenCnt), 32'd0);
    rst_n = 1'b1;
    inValid = 1'b0;

    // Directed vector table, each from IDLE
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].v, vecs[i].br, vecs[i].pc, vecs[i].im, vecs[i].rs, vecs[i].rt);
      chk($sformatf("vec%0d pcBranch", i), 32'(pcBranch), 32'(vecs[i].exp_pc));
      chk($sformatf("vec%0d originPc", i), 32'(originPc), 32'(vecs[i].exp_origin));
      chk($sformatf("vec%0d takenCnt", i), 32'(takenCnt), 32'(vecs[i].exp_cnt));
      drain();
    end

    // Squash: taken branches during REDIRECT/FLUSH are ignored
    cycle(1'b1, 3'd5, 10'h200, 10'd4, 16'd0, 16'd0);
    chk("sq redirect pc", 32'(pcBranch), 32'h210);
    for (int k = 0; k < FC + 1; k++) begin
      cycle(1'b1, 3'd1, 10'h000, 10'd1, 16'd9, 16'd9);
      chk($sformatf("sq busy%0d cnt", k), 32'(takenCnt), 32'd6);
      chk($sformatf("sq busy%0d origin", k), 32'(originPc), 32'd0);
    end
    chk("sq idle busy", 32'(busy), 32'd0);
    cycle(1'b1, 3'd1, 10'h000, 10'd1, 16'd9, 16'd9);
    chk("sq next accepted origin", 32'(originPc), 32'd1);
    chk("sq next accepted pc",     32'(pcBranch), 32'h004);
    chk("sq next accepted cnt",    32'(takenCnt), 32'd7);
    drain();

    // Asynchronous reset in the middle of FLUSH
    cycle(1'b1, 3'd5, 10'h080, 10'd1, 16'd0, 16'd0);
    cycle(1'b0, 3'd0, 10'h000, 10'd0, 16'd0, 16'd0);
    chk("mid flush busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid rst originPc", 32'(originPc), 32'd0);
    chk("mid rst flush",    32'(flush),    32'd0);
    chk("mid rst busy",     32'(busy),     32'd0);
    chk("mid rst takenCnt", 32'(takenCnt), 32'd0);
    chk("mid rst pcBranch", 32'(pcBranch), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 3'd6, 10'h000, 10'd0, 16'h0033, 16'd0);
    chk("post rst redirect pc", 32'(pcBranch), 32'h030);
    drain();

    // Saturation: preload the counter just below the ceiling
    @(negedge clk);
    force dut.taken_cnt_q = 16'hFFFE;
    #1;
    release dut.taken_cnt_q;
    m_cnt = 65534;
    cycle(1'b1, 3'd1, 10'h000, 10'd2, 16'd1, 16'd1);
    chk("sat reach", 32'(takenCnt), 32'hFFFF);
    drain();
    cycle(1'b1, 3'd2, 10'h000, 10'd2, 16'd1, 16'd2);
    chk("sat hold", 32'(takenCnt), 32'hFFFF);
    chk("sat redirect still", 32'(originPc), 32'd1);
    drain();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) rand_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
